// File: rtl/can_rx_fifo.sv
// -----------------------------------------------------------------------------
// can_rx_fifo
// Receive-side frame buffer between the CAN packet layer and the consumer.
// Applies an ID acceptance filter, stores accepted frames in a small
// first-word-fall-through FIFO and returns a one-cycle registered ACK pulse
// for every frame it takes. Frames that fail the filter or find no free slot
// are dropped and tallied in saturating counters.
//
// Parameters
//   DEPTH     : number of frame slots, power of two in 2..16
//   FILT_ID   : acceptance ID pattern
//   FILT_MASK : ID bits compared against FILT_ID (1 = compare, 0 = don't care)
//
// Ports
//   clk, rstn          : single rising-edge clock, async active-low reset
//   rx_valid           : one-cycle pulse, CRC-good frame present
//   rx_id/ide/rtr/len/data : incoming frame fields
//   rx_ack             : registered acceptance pulse, one cycle after rx_valid
//   out_valid/out_ready: FWFT head handshake
//   out_id/ide/rtr/len/data : head frame fields (valid while out_valid)
//   flush              : synchronous FIFO clear (counters retained)
//   level              : frames currently stored, 0..DEPTH
//   ovf_cnt, filt_cnt  : saturating drop counters (no space / filtered)
// -----------------------------------------------------------------------------
module can_rx_fifo #(
    parameter int          DEPTH     = 4,
    parameter logic [28:0] FILT_ID   = 29'h0,
    parameter logic [28:0] FILT_MASK = 29'h0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        rx_valid,
    input  logic [28:0] rx_id,
    input  logic        rx_ide,
    input  logic        rx_rtr,
    input  logic [3:0]  rx_len,
    input  logic [63:0] rx_data,
    output logic        rx_ack,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [28:0] out_id,
    output logic        out_ide,
    output logic        out_rtr,
    output logic [3:0]  out_len,
    output logic [63:0] out_data,
    input  logic        flush,
    output logic [4:0]  level,
    output logic [15:0] ovf_cnt,
    output logic [15:0] filt_cnt
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [4:0]  DEPTH_L = 5'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    // Frame storage, {id, ide, rtr, len, data}; not reset.
    logic [98:0]   mem_r [DEPTH];

    logic [AW-1:0] wptr_r;
    logic [AW-1:0] rptr_r;
    logic [4:0]    level_r;
    logic          rx_ack_r;
    logic [15:0]   ovf_cnt_r;
    logic [15:0]   filt_cnt_r;

    logic          match_s;
    logic          pop_s;
    logic          space_s;
    logic          push_s;
    logic          filt_drop_s;
    logic          ovf_drop_s;
    logic [98:0]   head_s;

    // Filter match, free-slot detection and push/pop/drop decisions.
    always_comb begin
        match_s     = 1'b0;
        pop_s       = 1'b0;
        space_s     = 1'b0;
        push_s      = 1'b0;
        filt_drop_s = 1'b0;
        ovf_drop_s  = 1'b0;
        match_s = (((rx_id ^ FILT_ID) & FILT_MASK) == 29'h0);
        // A pop in the same cycle frees a slot, so a full FIFO can still accept.
        pop_s   = (level_r != 5'd0) && out_ready;
        space_s = (level_r < DEPTH_L) || pop_s;
        if (flush) begin
            push_s      = 1'b0;
            filt_drop_s = 1'b0;
            ovf_drop_s  = 1'b0;
        end else begin
            push_s      = rx_valid && match_s && space_s;
            filt_drop_s = rx_valid && !match_s;
            ovf_drop_s  = rx_valid && match_s && !space_s;
        end
    end

    // Pointers, occupancy and the registered ACK pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_r   <= '0;
            rptr_r   <= '0;
            level_r  <= 5'd0;
            rx_ack_r <= 1'b0;
        end else if (flush) begin
            // Flush wins over any same-cycle push or pop.
            wptr_r   <= '0;
            rptr_r   <= '0;
            level_r  <= 5'd0;
            rx_ack_r <= 1'b0;
        end else begin
            rx_ack_r <= push_s;
            if (push_s) begin
                wptr_r <= wptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rptr_r <= rptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + 5'd1;
                2'b01:   level_r <= level_r - 5'd1;
                default: level_r <= level_r;
            endcase
        end
    end

    // Saturating drop counters; flush leaves them untouched.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ovf_cnt_r  <= 16'h0000;
            filt_cnt_r <= 16'h0000;
        end else begin
            if (filt_drop_s && (filt_cnt_r != 16'hFFFF)) begin
                filt_cnt_r <= filt_cnt_r + 16'd1;
            end
            if (ovf_drop_s && (ovf_cnt_r != 16'hFFFF)) begin
                ovf_cnt_r <= ovf_cnt_r + 16'd1;
            end
        end
    end

    // Frame storage write port.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wptr_r] <= {rx_id, rx_ide, rx_rtr, rx_len, rx_data};
        end
    end

    // Head entry is presented straight from storage (first-word-fall-through).
    assign head_s    = mem_r[rptr_r];
    assign out_id    = head_s[98:70];
    assign out_ide   = head_s[69];
    assign out_rtr   = head_s[68];
    assign out_len   = head_s[67:64];
    assign out_data  = head_s[63:0];

    assign out_valid = (level_r != 5'd0);
    assign level     = level_r;
    assign rx_ack    = rx_ack_r;
    assign ovf_cnt   = ovf_cnt_r;
    assign filt_cnt  = filt_cnt_r;

endmodule
